// File: rtl/ipv4_arp_lut_requester.sv
// ARP table lookup client: issues lookup strobes for next-hop addresses and returns
// {found, MAC, tag, next hop} downstream in request order with bounded outstanding lookups.
module ipv4_arp_lut_requester #(
   parameter int MAC_WIDTH       = 48,
   parameter int TAG_WIDTH       = 8,
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_WIDTH       = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 i_req_valid,
   output logic                 o_req_ready,
   input  logic [31:0]          i_req_nh,
   input  logic [TAG_WIDTH-1:0] i_req_tag,
   output logic                 o_lut_daddr_valid,
   output logic [31:0]          o_lut_daddr,
   input  logic                 i_lut_valid,
   input  logic                 i_lut_found,
   input  logic [MAC_WIDTH-1:0] i_lut_eth_addr,
   output logic                 o_lut_rd,
   output logic                 o_rsp_valid,
   input  logic                 i_rsp_ready,
   output logic                 o_rsp_found,
   output logic [MAC_WIDTH-1:0] o_rsp_eth_addr,
   output logic [TAG_WIDTH-1:0] o_rsp_tag,
   output logic [31:0]          o_rsp_nh,
   output logic [CNT_WIDTH-1:0] o_lookup_cnt,
   output logic [CNT_WIDTH-1:0] o_miss_cnt,
   output logic                 o_err
);

   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int EW = 32 + TAG_WIDTH;
   localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
      return (&c) ? c : c + CNT_WIDTH'(1);
   endfunction

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
   endfunction

   logic [OW-1:0]        outstanding_p0;
   logic [OW-1:0]        outstanding_nxt;
   logic                 req_ready_p0;
   logic [PW-1:0]        wr_ptr_p0;
   logic [PW-1:0]        rd_ptr_p0;
   logic [EW-1:0]        fifo_mem [MAX_OUTSTANDING];
   logic [EW-1:0]        fifo_head;

   logic                 daddr_vld_p1;
   logic [31:0]          daddr_p1;

   logic                 rsp_vld_p1;
   logic                 rsp_found_p1;
   logic [MAC_WIDTH-1:0] rsp_mac_p1;
   logic [TAG_WIDTH-1:0] rsp_tag_p1;
   logic [31:0]          rsp_nh_p1;

   logic [CNT_WIDTH-1:0] lookup_cnt;
   logic [CNT_WIDTH-1:0] miss_cnt;
   logic                 err_q;

   logic                 accept;
   logic                 orphan;
   logic                 lut_rd;
   logic                 lut_load;
   logic                 rsp_xfer;

   // The tag FIFO holds exactly one entry per outstanding lookup, so its
   // occupancy is the outstanding count and no separate fill level is kept.
   assign accept    = i_req_valid && req_ready_p0;
   assign orphan    = (outstanding_p0 == '0);
   assign rsp_xfer  = rsp_vld_p1 && i_rsp_ready;
   assign lut_rd    = i_lut_valid && (!rsp_vld_p1 || i_rsp_ready);
   assign lut_load  = lut_rd && !orphan;
   assign fifo_head = fifo_mem[rd_ptr_p0];

   always_comb begin
      outstanding_nxt = outstanding_p0;
      case ({accept, lut_load})
         2'b10:   outstanding_nxt = outstanding_p0 + OW'(1);
         2'b01:   outstanding_nxt = outstanding_p0 - OW'(1);
         default: outstanding_nxt = outstanding_p0;
      endcase
   end

   // ---- p0: request acceptance and tag FIFO ----
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         outstanding_p0 <= '0;
         req_ready_p0   <= 1'b0;
         wr_ptr_p0      <= '0;
         rd_ptr_p0      <= '0;
      end else begin
         outstanding_p0 <= outstanding_nxt;
         req_ready_p0   <= (outstanding_nxt < MAX_O);
         if (accept)
            wr_ptr_p0 <= next_ptr(wr_ptr_p0);
         if (lut_load)
            rd_ptr_p0 <= next_ptr(rd_ptr_p0);
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         fifo_mem[wr_ptr_p0] <= {i_req_nh, i_req_tag};
   end

   // ---- p1: lookup strobe toward the ARP table ----
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         daddr_vld_p1 <= 1'b0;
         daddr_p1     <= '0;
      end else begin
         daddr_vld_p1 <= accept;
         if (accept)
            daddr_p1 <= i_req_nh;
      end
   end

   // ---- p1: response register, reloaded in the same cycle it drains ----
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rsp_vld_p1   <= 1'b0;
         rsp_found_p1 <= 1'b0;
         rsp_mac_p1   <= '0;
         rsp_tag_p1   <= '0;
         rsp_nh_p1    <= '0;
      end else if (lut_load) begin
         rsp_vld_p1   <= 1'b1;
         rsp_found_p1 <= i_lut_found;
         rsp_mac_p1   <= i_lut_eth_addr;
         rsp_tag_p1   <= fifo_head[TAG_WIDTH-1:0];
         rsp_nh_p1    <= fifo_head[EW-1:TAG_WIDTH];
      end else if (rsp_xfer) begin
         rsp_vld_p1   <= 1'b0;
      end
   end

   // ---- statistics and sticky error ----
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lookup_cnt <= '0;
         miss_cnt   <= '0;
         err_q      <= 1'b0;
      end else begin
         if (rsp_xfer)
            lookup_cnt <= sat_inc(lookup_cnt);
         if (rsp_xfer && !rsp_found_p1)
            miss_cnt <= sat_inc(miss_cnt);
         if (lut_rd && orphan)
            err_q <= 1'b1;
      end
   end

   assign o_req_ready       = req_ready_p0;
   assign o_lut_daddr_valid = daddr_vld_p1;
   assign o_lut_daddr       = daddr_p1;
   assign o_lut_rd          = lut_rd;
   assign o_rsp_valid       = rsp_vld_p1;
   assign o_rsp_found       = rsp_found_p1;
   assign o_rsp_eth_addr    = rsp_mac_p1;
   assign o_rsp_tag         = rsp_tag_p1;
   assign o_rsp_nh          = rsp_nh_p1;
   assign o_lookup_cnt      = lookup_cnt;
   assign o_miss_cnt        = miss_cnt;
   assign o_err             = err_q;

endmodule

// File: tb/tb_ipv4_arp_lut_requester.sv
// Bench for ipv4_arp_lut_requester: ARP table model with fixed pipeline delay and an
// output FIFO, plus a request-ordered scoreboard of expected responses.
module tb_ipv4_arp_lut_requester;

   localparam int MW = 48, TW = 8, MO = 4, CW = 32, TBL_LAT = 3;

   logic          clk = 1'b0;
   logic          resetn;
   logic          i_req_valid, o_req_ready;
   logic [31:0]   i_req_nh;
   logic [TW-1:0] i_req_tag;
   logic          o_lut_daddr_valid;
   logic [31:0]   o_lut_daddr;
   logic          i_lut_valid, i_lut_found;
   logic [MW-1:0] i_lut_eth_addr;
   logic          o_lut_rd;
   logic          o_rsp_valid, i_rsp_ready, o_rsp_found;
   logic [MW-1:0] o_rsp_eth_addr;
   logic [TW-1:0] o_rsp_tag;
   logic [31:0]   o_rsp_nh;
   logic [CW-1:0] o_lookup_cnt, o_miss_cnt;
   logic          o_err;

   always #5 clk = ~clk;

   ipv4_arp_lut_requester #(.MAC_WIDTH(MW), .TAG_WIDTH(TW), .MAX_OUTSTANDING(MO), .CNT_WIDTH(CW)) dut (
      .clk(clk), .resetn(resetn),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_nh(i_req_nh), .i_req_tag(i_req_tag),
      .o_lut_daddr_valid(o_lut_daddr_valid), .o_lut_daddr(o_lut_daddr),
      .i_lut_valid(i_lut_valid), .i_lut_found(i_lut_found), .i_lut_eth_addr(i_lut_eth_addr), .o_lut_rd(o_lut_rd),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_found(o_rsp_found),
      .o_rsp_eth_addr(o_rsp_eth_addr), .o_rsp_tag(o_rsp_tag), .o_rsp_nh(o_rsp_nh),
      .o_lookup_cnt(o_lookup_cnt), .o_miss_cnt(o_miss_cnt), .o_err(o_err)
   );

   typedef struct packed {
      logic          found;
      logic [MW-1:0] mac;
      logic [TW-1:0] tag;
      logic [31:0]   nh;
   } rsp_t;

   int n_cmp = 0, n_err = 0;

   task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, obs, exp, $time);
      end
   endtask

   // ARP table contents: two fixed entries, otherwise odd addresses resolve.
   function automatic logic [MW:0] tbl_lookup(input logic [31:0] a);
      if (a == 32'h0A000001) return {1'b1, 48'h001122334455};
      if (a == 32'hC0A80101) return {1'b0, 48'h0};
      if (a[0])              return {1'b1, 16'h02AB, a};
      return {1'b0, 48'h0};
   endfunction

   rsp_t          sb[$];
   logic [MW:0]   tbl_q[$];
   logic          stg_v [TBL_LAT];
   logic [31:0]   stg_a [TBL_LAT];
   bit            mon_en = 0, bp_mode = 0, inject = 0;
   bit            snap_strobe = 0, snap_pop = 0, acc_prev = 0, prev_stall = 0;
   logic [31:0]   snap_addr = '0, nh_prev = '0;
   rsp_t          prev_rsp, e, got;
   bit            acc, load;
   int            outst_m = 0, exp_lookups = 0, exp_miss = 0, max_tbl = 0;

   // Monitor: all DUT observation happens on the falling edge.
   always @(negedge clk) begin
      if (mon_en && resetn) begin
         check("req_ready", o_req_ready, outst_m < MO);
         check("strobe", o_lut_daddr_valid, acc_prev);
         if (acc_prev) check("daddr", o_lut_daddr, nh_prev);
         check("lut_rd", o_lut_rd, i_lut_valid && (!o_rsp_valid || i_rsp_ready));
         if (prev_stall)
            check("rsp_hold", {o_rsp_valid, o_rsp_found, o_rsp_eth_addr, o_rsp_tag, o_rsp_nh}, {1'b1, prev_rsp});
         if (o_rsp_valid && i_rsp_ready) begin
            if (sb.size() == 0) check("rsp_unexpected", 1, 0);
            else begin
               e = sb.pop_front();
               got = {o_rsp_found, o_rsp_eth_addr, o_rsp_tag, o_rsp_nh};
               check("rsp_found", got.found, e.found);
               check("rsp_mac", got.mac, e.mac);
               check("rsp_tag", got.tag, e.tag);
               check("rsp_nh", got.nh, e.nh);
               exp_lookups++;
               if (!e.found) exp_miss++;
            end
         end
         acc = i_req_valid && o_req_ready;
         if (acc) begin
            {e.found, e.mac} = tbl_lookup(i_req_nh);
            e.tag = i_req_tag;
            e.nh  = i_req_nh;
            sb.push_back(e);
         end
         load = o_lut_rd && (outst_m > 0);
         outst_m = outst_m + int'(acc) - int'(load);
         acc_prev    = acc;
         nh_prev     = i_req_nh;
         prev_stall  = o_rsp_valid && !i_rsp_ready;
         prev_rsp    = {o_rsp_found, o_rsp_eth_addr, o_rsp_tag, o_rsp_nh};
         snap_strobe = o_lut_daddr_valid;
         snap_addr   = o_lut_daddr;
         snap_pop    = o_lut_rd;
      end else begin
         acc_prev = 0; prev_stall = 0; outst_m = 0;
         snap_strobe = 0; snap_pop = 0;
      end
   end

   // ARP table model: fixed lookup pipeline feeding an output FIFO.
   initial begin
      for (int i = 0; i < TBL_LAT; i++) begin stg_v[i] = 0; stg_a[i] = '0; end
      forever begin
         @(posedge clk);
         #1;
         if (!resetn) begin
            tbl_q.delete();
            for (int i = 0; i < TBL_LAT; i++) stg_v[i] = 0;
         end else begin
            if (snap_pop && tbl_q.size() > 0) void'(tbl_q.pop_front());
            if (stg_v[TBL_LAT-1]) tbl_q.push_back(tbl_lookup(stg_a[TBL_LAT-1]));
            for (int i = TBL_LAT - 1; i > 0; i--) begin stg_v[i] = stg_v[i-1]; stg_a[i] = stg_a[i-1]; end
            stg_v[0] = snap_strobe;
            stg_a[0] = snap_addr;
            if (inject) begin tbl_q.push_back({1'b1, 48'hDEADBEEF0001}); inject = 0; end
            if (tbl_q.size() > max_tbl) max_tbl = tbl_q.size();
         end
         snap_pop = 0; snap_strobe = 0;
         i_lut_valid = (tbl_q.size() > 0);
         {i_lut_found, i_lut_eth_addr} = (tbl_q.size() > 0) ? tbl_q[0] : '0;
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (bp_mode) i_rsp_ready = ($urandom_range(0, 2) != 0);
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [31:0] nh, input logic [TW-1:0] tag);
      bit ok = 0;
      i_req_valid = 1; i_req_nh = nh; i_req_tag = tag;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (o_req_ready) ok = 1;
         @(posedge clk);
         #1;
      end
      i_req_valid = 0;
      check("accept", ok, 1);
   endtask

   task automatic drain(input string name);
      bit done = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(posedge clk);
         #1;
         if (sb.size() == 0 && !o_rsp_valid) done = 1;
      end
      check(name, done, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      resetn = 0; i_req_valid = 0; i_req_nh = '0; i_req_tag = '0; i_rsp_ready = 0;
      i_lut_valid = 0; i_lut_found = 0; i_lut_eth_addr = '0;
      #2;
      check("reset_outs", {o_req_ready, o_lut_daddr_valid, o_lut_daddr, o_rsp_valid, o_rsp_found,
                           o_rsp_eth_addr, o_rsp_tag, o_rsp_nh, o_err}, 0);
      check("reset_cnts", {o_lookup_cnt, o_miss_cnt}, 0);
      repeat (3) @(posedge clk);
      #1; resetn = 1;
      @(posedge clk);
      #1; mon_en = 1;
      check("ready_after_reset", o_req_ready, 1);

      // single hit
      i_rsp_ready = 1;
      send(32'h0A000001, 8'h05);
      drain("t1_drain");
      check("t1_lookup_cnt", o_lookup_cnt, 1);
      check("t1_miss_cnt", o_miss_cnt, 0);

      // single miss
      send(32'hC0A80101, 8'h07);
      drain("t2_drain");
      check("t2_lookup_cnt", o_lookup_cnt, 2);
      check("t2_miss_cnt", o_miss_cnt, 1);

      // fill to the outstanding limit under backpressure
      i_rsp_ready = 0;
      for (int t = 1; t <= 4; t++) send(32'h0A010000 + t, TW'(t));
      @(negedge clk);
      check("t3_full_ready", o_req_ready, 0);
      @(posedge clk);
      #1;
      send(32'h0A010005, 8'h05);
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("t3_head_tag", {o_rsp_valid, o_rsp_tag}, {1'b1, 8'h01});
      @(posedge clk);
      #1; i_rsp_ready = 1;
      drain("t3_drain");
      check("t3_lookup_cnt", o_lookup_cnt, 7);

      // random backpressure
      bp_mode = 1;
      for (int n = 0; n < 1000; n++) begin
         send($urandom, TW'($urandom_range(0, 255)));
         if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end
      drain("t4_drain");
      bp_mode = 0; i_rsp_ready = 1;
      @(posedge clk);
      #1;
      check("t4_lookup_cnt", o_lookup_cnt, exp_lookups);
      check("t4_miss_cnt", o_miss_cnt, exp_miss);
      check("t4_tbl_depth", max_tbl <= MO, 1);
      check("t4_err_clear", o_err, 0);

      // orphan table result
      inject = 1;
      begin
         bit seen = 0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i_lut_valid && !seen) begin seen = 1; check("t5_orphan_rd", o_lut_rd, 1); end
            check("t5_no_rsp", o_rsp_valid, 0);
         end
         check("t5_orphan_seen", seen, 1);
      end
      @(posedge clk);
      #1;
      check("t5_err", o_err, 1);
      send(32'h0A000003, 8'h09);
      drain("t5_drain");
      check("t5_err_sticky", o_err, 1);

      // async reset with lookups in flight
      for (int t = 0; t < 3; t++) send(32'h0B000001 + 2 * t, TW'(t + 20));
      #2;
      resetn = 0; mon_en = 0;
      i_lut_valid = 0; i_lut_found = 0; i_lut_eth_addr = '0;
      sb.delete(); exp_lookups = 0; exp_miss = 0;
      #1;
      check("t6_reset_outs", {o_req_ready, o_lut_daddr_valid, o_lut_daddr, o_rsp_valid, o_rsp_found,
                              o_rsp_eth_addr, o_rsp_tag, o_rsp_nh, o_err, o_lut_rd}, 0);
      check("t6_reset_cnts", {o_lookup_cnt, o_miss_cnt}, 0);
      repeat (2) @(posedge clk);
      #1; resetn = 1;
      @(posedge clk);
      #1; mon_en = 1;
      check("t6_ready", o_req_ready, 1);
      check("t6_err", o_err, 0);
      send(32'h0A000001, 8'h33);
      drain("t6_drain");
      check("t6_lookup_cnt", o_lookup_cnt, 1);
      check("t6_miss_cnt", o_miss_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
